// File: rtl/spi_pkg.sv
// Shared types for the SPI frame sequencer: controller states, frame size
// and the bit-index type used to walk a frame MSB first.
package spi_pkg;

  localparam int FRAME_BITS = 16;

  typedef logic [3:0] sel_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase counter for the SCLK divider. Counts CLK_DIV clk cycles per phase,
// flags the last cycle of the phase with tc and wraps to zero on its own,
// so every phase change in the controller starts from a fresh count.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  // 8 bits cover CLK_DIV up to 255; the count never exceeds CLK_DIV-1.
  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tc = (div_cnt == LAST_CNT);

  // Count clk cycles within a phase, restarting at zero on clear or at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || tc) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI mode-0 frame sequencer. Accepts a 16-bit word on start, walks the bit
// index sel from 15 down to 0 for an external bit mux, generates SCLK and
// chip select, samples sdi on each SCLK rising edge and presents the
// received word with a one-cycle done pulse at the end of the frame.
module spi_frame_sequencer #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = spi_pkg::FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  sdi,
  output logic [FRAME_BITS-1:0] tx_word,
  output logic [3:0]            sel,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data
);

  import spi_pkg::*;

  localparam sel_t FIRST_SEL = sel_t'(FRAME_BITS - 1);

  state_t                state;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  tc;
  logic                  div_clear;

  // The divider is held at zero while idle so the first setup phase is full length.
  assign div_clear = (state == IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(div_clear),
    .tc   (tc)
  );

  // Frame controller: phase sequencing with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      tx_word  <= '0;
      rx_data  <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            tx_word <= data_in;
            sel     <= FIRST_SEL;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tc) begin
            state <= LOW;
          end
        end
        LOW: begin
          if (tc) begin
            sclk          <= 1'b1;
            rx_shift[sel] <= sdi;
            state         <= HIGH;
          end
        end
        HIGH: begin
          if (tc) begin
            sclk <= 1'b0;
            if (sel == '0) begin
              state <= HOLD;
            end else begin
              sel   <= sel - 4'd1;
              state <= LOW;
            end
          end
        end
        HOLD: begin
          if (tc) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_shift;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: a table of looped/constant
// sdi frames on a CLK_DIV=2 instance, plus hand sequences for the ignored
// start, mid-frame reset and back-to-back frames on a CLK_DIV=1 instance.
module tb_spi_frame_sequencer;

  typedef enum logic [1:0] {SDI_LOOP, SDI_ZERO, SDI_ONE} sdi_mode_t;

  typedef struct {
    logic [15:0] data;
    sdi_mode_t   mode;
    logic [15:0] exp_rx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // CLK_DIV = 2 instance
  logic        start2 = 1'b0;
  logic [15:0] din2 = 16'h0000;
  sdi_mode_t   mode2 = SDI_LOOP;
  logic        sdi2;
  logic [15:0] txw2, rx2;
  logic [3:0]  sel2;
  logic        sclk2, csn2, busy2, done2;

  assign sdi2 = (mode2 == SDI_LOOP) ? txw2[sel2] : (mode2 == SDI_ONE);

  spi_frame_sequencer #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(din2), .sdi(sdi2),
    .tx_word(txw2), .sel(sel2), .sclk(sclk2), .cs_n(csn2), .busy(busy2),
    .done(done2), .rx_data(rx2)
  );

  // CLK_DIV = 1 instance
  logic        start1 = 1'b0;
  logic [15:0] din1 = 16'h0000;
  logic        sdi1;
  logic [15:0] txw1, rx1;
  logic [3:0]  sel1;
  logic        sclk1, csn1, busy1, done1;

  assign sdi1 = 1'b1;

  spi_frame_sequencer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(din1), .sdi(sdi1),
    .tx_word(txw1), .sel(sel1), .sclk(sclk1), .cs_n(csn1), .busy(busy1),
    .done(done1), .rx_data(rx1)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit index n cycles after the accepting edge.
  function automatic logic [3:0] exp_sel(input int n, input int d);
    if (n < 3 * d) return 4'd15;
    if (n >= 33 * d) return 4'd0;
    return 4'(15 - (n - d) / (2 * d));
  endfunction

  // Expected SCLK level n cycles after the accepting edge.
  function automatic logic exp_sclk(input int n, input int d);
    return (n >= d) && (n < 33 * d) && (((n - d) % (2 * d)) >= d);
  endfunction

  function automatic bit trace_bad(input int n, input int d, input logic [3:0] s,
                                   input logic sc, input logic cs, input logic bz);
    return (s !== exp_sel(n, d)) || (sc !== exp_sclk(n, d)) || (cs !== 1'b0) || (bz !== 1'b1);
  endfunction

  // One frame on the CLK_DIV=2 instance; start is re-pulsed at cycle inject_n when >= 0.
  task automatic apply_stimulus(input logic [15:0] data, input sdi_mode_t mode,
                                input logic [15:0] exp_rx, input int inject_n);
    int n;
    int rises;
    int bad_n;
    logic prev_sclk;
    logic [15:0] old_rx;
    old_rx = rx2;
    mode2  = mode;
    din2   = data;
    start2 = 1'b1;
    tick();
    start2    = 1'b0;
    din2      = ~data;
    n         = 0;
    rises     = 0;
    bad_n     = -1;
    prev_sclk = 1'b0;
    while (n <= 80) begin
      if (done2) break;
      if (sclk2 && !prev_sclk) rises++;
      prev_sclk = sclk2;
      if (bad_n < 0 && (trace_bad(n, 2, sel2, sclk2, csn2, busy2) ||
                        txw2 !== data || rx2 !== old_rx))
        bad_n = n;
      start2 = (n == inject_n);
      tick();
      n++;
    end
    start2 = 1'b0;
    check_output("frame latency", 32'(n), 32'd68);
    check_output("frame trace first bad cycle", 32'(bad_n), 32'hFFFF_FFFF);
    check_output("sclk rising edges", 32'(rises), 32'd16);
    check_output("rx_data at done", 32'(rx2), 32'(exp_rx));
    check_output("tx_word at done", 32'(txw2), 32'(data));
    check_output("idle at done", {28'd0, csn2, busy2, sclk2, 1'b0}, 32'h8);
    check_output("sel at done", 32'(sel2), 32'd0);
    tick();
    check_output("done one cycle", 32'(done2), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int dcount;
    int n;
    int rises;
    int bad_n;
    logic prev_sclk;

    vecs[0] = '{16'hA5C3, SDI_LOOP, 16'hA5C3};
    vecs[1] = '{16'h0000, SDI_LOOP, 16'h0000};
    vecs[2] = '{16'hFFFF, SDI_LOOP, 16'hFFFF};
    vecs[3] = '{16'h1234, SDI_ZERO, 16'h0000};
    vecs[4] = '{16'h8001, SDI_ONE,  16'hFFFF};
    vecs[5] = '{16'h5A5A, SDI_LOOP, 16'h5A5A};

    // reset state, then one clock with reset released
    tick();
    check_output("reset cs_n/busy/done/sclk", {28'd0, csn2, busy2, done2, sclk2}, 32'h8);
    rst_n = 1'b1;
    tick();
    check_output("post-reset sel", 32'(sel2), 32'd0);
    check_output("post-reset cs_n/busy/sclk", {29'd0, csn2, busy2, sclk2}, 32'h4);
    check_output("post-reset rx_data", 32'(rx2), 32'd0);
    check_output("post-reset tx_word", 32'(txw2), 32'd0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].mode, vecs[i].exp_rx, -1);
      tick();
    end

    // start pulse at cycle 10 of a frame must be ignored
    apply_stimulus(16'h3C96, SDI_LOOP, 16'h3C96, 10);
    dcount = 0;
    for (int i = 0; i < 80; i++) begin
      if (done2 || busy2) dcount++;
      tick();
    end
    check_output("no queued frame after ignored start", 32'(dcount), 32'd0);
    check_output("tx_word after ignored start", 32'(txw2), 32'h3C96);

    // reset asserted at cycle 30 aborts the frame
    mode2  = SDI_LOOP;
    din2   = 16'hBEEF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check_output("cs_n low before abort", 32'(csn2), 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("abort cs_n/busy/sclk", {29'd0, csn2, busy2, sclk2}, 32'h4);
    check_output("abort rx_data", 32'(rx2), 32'd0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done2) dcount++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done2 || !csn2) dcount++;
    end
    check_output("no done after abort", 32'(dcount), 32'd0);
    apply_stimulus(16'h0001, SDI_LOOP, 16'h0001, -1);

    // CLK_DIV=1, start held high, sdi tied to 1: back-to-back frames
    start1 = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      n         = 0;
      rises     = 0;
      bad_n     = -1;
      prev_sclk = 1'b0;
      while (n <= 50) begin
        if (done1) break;
        if (sclk1 && !prev_sclk) rises++;
        prev_sclk = sclk1;
        if (bad_n < 0 && trace_bad(n, 1, sel1, sclk1, csn1, busy1)) bad_n = n;
        tick();
        n++;
      end
      check_output("div1 frame latency", 32'(n), 32'd34);
      check_output("div1 trace first bad cycle", 32'(bad_n), 32'hFFFF_FFFF);
      check_output("div1 sclk rising edges", 32'(rises), 32'd16);
      check_output("div1 rx_data", 32'(rx1), 32'hFFFF);
      check_output("div1 idle gap cs_n", 32'(csn1), 32'd1);
      if (f == 2) start1 = 1'b0;
      tick();
      check_output("div1 next frame started", {30'd0, csn1, busy1}, (f < 2) ? 32'h1 : 32'h2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
